// File: rtl/modexp_pkg.sv
// modexp_pkg: shared FSM state type and latency/bit-length helpers for the modexp engine.
package modexp_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REDUCE, S_MUL, S_DONE} state_t;

  function automatic int modexp_latency(input int width, input int explen);
    return 3 + (explen + 1) * (width + 1);
  endfunction

  function automatic int bit_len(input logic [127:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 128; i++)
      if (v[i]) n = i + 1;
    return n;
  endfunction
endpackage

// File: rtl/modexp_param_modmul.sv
// modmul_serial: bit-serial interleaved a*b mod N, one bit of b per cycle, MSB-first.
module modmul_serial
  import modexp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_go,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_N,
  output logic [WIDTH-1:0] o_p,
  output logic             o_done
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] a_q, b_q, n_q;
  logic [WIDTH:0]   acc, dbl, t1, sum, t2;
  logic [CW-1:0]    cnt;
  logic             busy, last;

  // acc stays below N, so doubling and the add each fit in WIDTH+1 bits
  always_comb begin
    dbl  = acc << 1;
    t1   = (dbl >= {1'b0, n_q}) ? dbl - {1'b0, n_q} : dbl;
    sum  = t1 + (b_q[WIDTH-1] ? {1'b0, a_q} : '0);
    t2   = (sum >= {1'b0, n_q}) ? sum - {1'b0, n_q} : sum;
    last = cnt == CW'(WIDTH - 1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      o_done <= 1'b0;
    end else if (i_go) begin
      a_q    <= i_a;
      b_q    <= i_b;
      n_q    <= i_N;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
      o_done <= 1'b0;
    end else begin
      o_done <= busy && last;
      if (busy) begin
        acc  <= t2;
        b_q  <= b_q << 1;
        cnt  <= cnt + 1'b1;
        busy <= !last;
      end
    end
  end

  assign o_p = acc[WIDTH-1:0];
endmodule

// File: rtl/modexp_param.sv
// modexp_param: sequential (base^exp) mod N using two serial modular multipliers
// (x path and r path); REDUCE pre-reduces the base through the r multiplier.
module modexp_param
  import modexp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_base,
  input  logic [WIDTH-1:0] i_exp,
  input  logic [WIDTH-1:0] i_N,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);
  state_t           state, nxt;
  logic             start_q, start_edge;
  logic [WIDTH-1:0] exp_q, n_q, x, x_now, exp_run;
  logic [WIDTH-1:0] r_p, x_p, r_a, r_b, r_n;
  logic             r_go, x_go, r_done, x_done, more, in_phase, load;
  logic [31:0]      run_cyc;

  always_comb begin
    load     = state == S_LOAD;
    in_phase = state == S_REDUCE || state == S_MUL;
    more     = (state == S_REDUCE) ? exp_q != '0 : (exp_q >> 1) != '0;
    x_now    = (state == S_MUL && exp_q[0]) ? x_p : x;
    // next phase starts on the same edge the current one is consumed
    r_go     = (load && i_N != '0) || (in_phase && r_done && more);
    x_go     = in_phase && r_done && more && ((state == S_REDUCE) ? exp_q[0] : exp_q[1]);
    r_a      = load ? WIDTH'(1) : r_p;
    r_b      = load ? i_base : r_p;
    r_n      = load ? i_N : n_q;
    o_busy   = load || in_phase;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:           nxt = start_edge ? S_LOAD : S_IDLE;
      S_LOAD:           nxt = (i_N == '0) ? S_DONE : S_REDUCE;
      S_REDUCE, S_MUL:  nxt = r_done ? (more ? S_MUL : S_DONE) : state;
      default:          nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      start_edge <= 1'b0;
      exp_q      <= '0;
      n_q        <= '0;
      x          <= '0;
      o_result   <= '0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state      <= nxt;
      start_q    <= i_start;
      start_edge <= i_start && !start_q;
      o_done     <= state == S_DONE;
      if (load) begin
        exp_q <= i_exp;
        n_q   <= i_N;
        x     <= (i_N <= WIDTH'(1)) ? '0 : WIDTH'(1);
        o_err <= 1'b0;
      end
      if (state == S_MUL && r_done) begin
        x     <= x_now;
        exp_q <= exp_q >> 1;
      end
      if (state == S_DONE) begin
        o_result <= x;
        o_err    <= n_q == '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      run_cyc <= '0;
      exp_run <= '0;
    end else begin
      run_cyc <= (state == S_IDLE && start_edge) ? 32'd1 : run_cyc + 32'd1;
      if (load) exp_run <= i_exp;
      if (o_done)
        assert (run_cyc == 32'(o_err ? 3 : modexp_latency(WIDTH, bit_len(128'(exp_run)))));
      if (state == S_MUL && r_done && exp_q[0])
        assert (x_done);
    end
  end

  modmul_serial #(.WIDTH(WIDTH)) u_mul_r (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_go(r_go), .i_a(r_a), .i_b(r_b), .i_N(r_n),
    .o_p(r_p), .o_done(r_done)
  );

  modmul_serial #(.WIDTH(WIDTH)) u_mul_x (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_go(x_go), .i_a(x_now), .i_b(r_p), .i_N(n_q),
    .o_p(x_p), .o_done(x_done)
  );
endmodule

// File: doc/modexp_param.md
# modexp_param

Parametrised, sequential modular-exponentiation engine computing `o_result = (i_base ^ i_exp) mod i_N` for operands of `WIDTH` bits. It is the next-generation exponentiation core for the crypto IP group. The wide single-cycle `*`/`%` datapath is replaced by two bit-serial interleaved modular multipliers, giving deterministic latency, timing closure at any `WIDTH`, busy/done/error handshaking and base pre-reduction. It sits behind the bus-slave register wrapper, which drives operands and a start level and polls `o_busy`/`o_done`.

## Interface
- `WIDTH`, default 32: operand/modulus width in bits; legal range ≥ 4.
- `i_clk` input 1: sole clock, rising edge.
- `i_rstn` input 1: reset, synchronous, active-low.
- `i_start` input 1: start level. Internally edge-detected; only a low→high transition launches a run.
- `i_base` input WIDTH: base; any value, including values ≥ N.
- `i_exp` input WIDTH: exponent.
- `i_N` input WIDTH: modulus; 0 is illegal.
- `o_result` output WIDTH: last result, held until the next completion. Reset value 0.
- `o_busy` output 1: high from the LOAD state through the last MUL cycle. Reset value 0.
- `o_done` output 1: one-cycle completion pulse. Reset value 0.
- `o_err` output 1: high with `o_done` when N was 0; holds until the next start. Reset value 0.

## Operation
- **FSM states:** IDLE → LOAD → REDUCE → MUL → DONE → IDLE.
- **IDLE:** wait for a start edge. A start edge in any other state is ignored and is not queued.
- **LOAD (1 cycle):**
  - Latch base, exp and N.
  - `x` = 1, or 0 if N == 1.
  - If N == 0: go to DONE with the error flag set, `o_result` = 0.
- **REDUCE:** run the multiplier as `r = 1·base mod N`, scanning base bits MSB-first. This makes `r < N`.
- **MUL:** per exponent bit, LSB-first:
  - Both multiplier instances start together from the current `r`: `x' = x·r mod N` (only if the bit is 1, otherwise `x` is held) and `r' = r·r mod N`.
  - Shift exp right by 1.
  - Exit to DONE when the shifted exp is 0.
  - exp == 0 skips MUL entirely, giving `1 mod N`.
- **DONE (1 cycle):** `o_result` ← `x`, pulse `o_done`, go to IDLE.
- **Multiplier (`a·b mod N`, precondition `a < N`):**
  - Accumulator is WIDTH+1 bits.
  - Per bit of `b`, MSB-first: `acc = 2·acc`, subtract N if ≥ N; then, if the bit is set, `acc += a`, subtract N if ≥ N.
  - Both compare-subtracts happen in one cycle.
  - No intermediate may exceed WIDTH+1 bits.
- **Reset mid-run:** returns to IDLE with all outputs at their reset values; the run is abandoned.

## Timing
- **Multiplier timing:**
  - Go sampled on edge k.
  - Iterations on edges k+1 … k+WIDTH.
  - Result valid and `done` high in the cycle after edge k+WIDTH.
  - Each phase therefore costs WIDTH+1 cycles.
- **Top-level latency:** `o_done` rises exactly `3 + (B+1)·(WIDTH+1)` cycles after the edge that samples the start transition.
  - B = bit length of exp (0 for exp == 0).
  - The N == 0 error path takes 3 cycles.
- **Output updates:** `o_result` and `o_err` update on the same edge that raises `o_done`.
- **Back-to-back runs:** a new start edge is accepted in the cycle `o_done` is high, provided start was low the previous cycle. Minimum re-issue gap is 2 cycles.
- **Start held high:** exactly one run.

## Structure
- **Package `modexp_pkg`:**
  - FSM state enum (IDLE, LOAD, REDUCE, MUL, DONE).
  - Function `modexp_latency(width, explen)`, shared by RTL assertions and the bench.
- **Sub-module `modmul_serial`** (parameter WIDTH):
  - Ports: `i_go`, `i_a`, `i_b`, `i_N`, `o_p`, `o_done`.
  - Instantiated twice (`x` path, `r` path); the REDUCE phase uses the `r` instance.
- **Start edge detector:** an inline register in the top module, not a separate module.

## Test plan
- **Basic:** WIDTH=32, base 4, exp 13, N 497 → result 445, `o_done` 168 cycles after start, `o_err` = 0.
- **Pre-reduction:** base 0xFFFFFFFF, exp 1, N 1000 → 295. Also base 5, exp 3, N 13 → 8.
- **Edge cases:**
  - exp 0, base 7, N 10 → 1, latency 36.
  - N = 1, any base/exp → 0.
  - N = 0 → `o_err` = 1, result 0, latency 3.
- **Handshake:**
  - Start held high for 500 cycles → single `o_done`.
  - Second start edge while busy is ignored.
  - Back-to-back runs with a 2-cycle gap both complete correctly.
- **Reset:** `i_rstn` low at cycle 50 of a run → next edge gives `o_busy` = 0, `o_result` = 0, state IDLE. A fresh run afterwards is correct.
- **Parametric:** WIDTH=8 and WIDTH=64 with 1000 random vectors each, checked against a software model for result and latency.
